if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage_pkg.sv | 24 ++
 rtl/if_stage_if.sv | 13 +
 rtl/if_stage.sv | 160 ++++++++++++++++
 tb/tb_if_stage.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction fetch stage: stall bus layout,
// FSM encodings and architectural constants.
package if_stage_pkg;

   localparam int STALL_W   = 6;
   localparam int STALL_PC  = 0;
   localparam int STALL_IF  = 1;
   localparam int STALL_ID  = 2;
   localparam int STALL_EX  = 3;
   localparam int STALL_MEM = 4;
   localparam int STALL_WB  = 5;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP_INST = 32'h0000_0013;
   localparam logic [31:0] PC_STEP  = 32'd4;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_FETCH   = 2'd1,
      S_HOLD    = 2'd2,
      S_DISCARD = 2'd3
   } fetch_state_t;

endpackage

// File: rtl/if_stage_if.sv
// Fetch-side memory handshake between the IF stage (master) and the
// instruction memory controller (slave).
interface if_stage_if;
   logic        mem_req_o;
   logic [31:0] mem_addr_o;
   logic        mem_ack_i;
   logic [31:0] mem_data_i;

   modport master (output mem_req_o, output mem_addr_o,
                   input  mem_ack_i, input  mem_data_i);
   modport slave  (input  mem_req_o, input  mem_addr_o,
                   output mem_ack_i, output mem_data_i);
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: issues word fetches, buffers a word while IF is
// stalled, and squashes in-flight fetches on a branch redirect.
//
// state     | meaning
// S_IDLE    | no request outstanding; issues the next fetch unless PC stalled
// S_FETCH   | request outstanding, word will be delivered or buffered
// S_HOLD    | word parked in the hold buffer until IF stall releases
// S_DISCARD | request outstanding for a squashed fetch; its data is dropped
module if_stage
   import if_stage_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               rdy,
   input  logic [STALL_W-1:0] stall,
   input  logic               branch_flag_i,
   input  logic [31:0]        branch_target_i,
   if_stage_if.master         mem,
   output logic               if_stall_o,
   output logic [31:0]        if_pc_o,
   output logic [31:0]        if_inst_o,
   output logic               if_valid_o
);

   fetch_state_t r_state, w_state_nxt;
   logic [31:0]  r_pc, w_pc_nxt;
   logic         r_mem_req, w_req_nxt;
   logic [31:0]  r_mem_addr, w_addr_nxt;
   logic [31:0]  r_hold_pc, w_hold_pc_nxt;
   logic [31:0]  r_hold_inst, w_hold_inst_nxt;
   logic [31:0]  r_if_pc, w_out_pc_nxt;
   logic [31:0]  r_if_inst, w_out_inst_nxt;
   logic         r_if_valid, w_out_valid_nxt;
   logic         w_load;
   logic         w_unused_stall;

   assign w_unused_stall = ^stall[STALL_WB:STALL_EX];

   always_comb begin
      w_state_nxt     = r_state;
      w_pc_nxt        = r_pc;
      w_req_nxt       = r_mem_req;
      w_addr_nxt      = r_mem_addr;
      w_hold_pc_nxt   = r_hold_pc;
      w_hold_inst_nxt = r_hold_inst;
      w_out_pc_nxt    = r_if_pc;
      w_out_inst_nxt  = r_if_inst;
      w_out_valid_nxt = r_if_valid;
      w_load          = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (!stall[STALL_PC]) begin
               w_req_nxt   = 1'b1;
               w_addr_nxt  = r_pc;
               w_state_nxt = S_FETCH;
            end
         end
         S_FETCH: begin
            if (mem.mem_ack_i) begin
               w_pc_nxt  = r_pc + PC_STEP;
               w_req_nxt = 1'b0;
               if (!stall[STALL_IF]) begin
                  w_load         = 1'b1;
                  w_out_pc_nxt   = r_pc;
                  w_out_inst_nxt = mem.mem_data_i;
                  w_state_nxt    = S_IDLE;
               end else begin
                  w_hold_pc_nxt   = r_pc;
                  w_hold_inst_nxt = mem.mem_data_i;
                  w_state_nxt     = S_HOLD;
               end
            end
         end
         S_HOLD: begin
            if (!stall[STALL_IF]) begin
               w_load         = 1'b1;
               w_out_pc_nxt   = r_hold_pc;
               w_out_inst_nxt = r_hold_inst;
               w_state_nxt    = S_IDLE;
            end
         end
         S_DISCARD: begin
            if (mem.mem_ack_i) begin
               w_req_nxt   = 1'b0;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase

      // A bubble is inserted unless ID is stalled, in which case outputs freeze.
      if (w_load)
         w_out_valid_nxt = 1'b1;
      else if (!stall[STALL_ID])
         w_out_valid_nxt = 1'b0;

      if (branch_flag_i) begin
         w_pc_nxt        = branch_target_i;
         w_out_valid_nxt = 1'b0;
         w_out_pc_nxt    = r_if_pc;
         w_out_inst_nxt  = r_if_inst;
         w_hold_pc_nxt   = '0;
         w_hold_inst_nxt = '0;
         case (r_state)
            S_FETCH: begin
               w_req_nxt   = !mem.mem_ack_i;
               w_addr_nxt  = r_mem_addr;
               w_state_nxt = mem.mem_ack_i ? S_IDLE : S_DISCARD;
            end
            S_DISCARD: ;
            default: begin
               w_req_nxt   = r_mem_req;
               w_addr_nxt  = r_mem_addr;
               w_state_nxt = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_pc        <= RESET_PC;
         r_mem_req   <= 1'b0;
         r_mem_addr  <= '0;
         r_hold_pc   <= '0;
         r_hold_inst <= '0;
         r_if_pc     <= '0;
         r_if_inst   <= '0;
         r_if_valid  <= 1'b0;
      end else if (rdy) begin
         r_state     <= w_state_nxt;
         r_pc        <= w_pc_nxt;
         r_mem_req   <= w_req_nxt;
         r_mem_addr  <= w_addr_nxt;
         r_hold_pc   <= w_hold_pc_nxt;
         r_hold_inst <= w_hold_inst_nxt;
         r_if_pc     <= w_out_pc_nxt;
         r_if_inst   <= w_out_inst_nxt;
         r_if_valid  <= w_out_valid_nxt;
      end
   end

   always_comb begin
      if_stall_o = 1'b1;
      case (r_state)
         S_FETCH: if_stall_o = !mem.mem_ack_i;
         S_HOLD:  if_stall_o = 1'b0;
         default: if_stall_o = 1'b1;
      endcase
   end

   assign mem.mem_req_o  = r_mem_req;
   assign mem.mem_addr_o = r_mem_addr;
   assign if_pc_o        = r_if_pc;
   assign if_inst_o      = r_if_inst;
   assign if_valid_o     = r_if_valid;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a fixed-latency instruction memory that
// acks three cycles after each request.
module tb_if_stage;
   import if_stage_pkg::*;

   localparam int MEM_LAT = 3;

   logic               clk;
   logic               rst;
   logic               rdy;
   logic [STALL_W-1:0] stall;
   logic               branch_flag_i;
   logic [31:0]        branch_target_i;
   logic               if_stall_o;
   logic [31:0]        if_pc_o;
   logic [31:0]        if_inst_o;
   logic               if_valid_o;

   int total = 0;
   int bad   = 0;
   int mem_cnt;
   int n;
   logic [31:0] a;

   if_stage_if u_mem ();

   if_stage dut (
      .clk             (clk),
      .rst             (rst),
      .rdy             (rdy),
      .stall           (stall),
      .branch_flag_i   (branch_flag_i),
      .branch_target_i (branch_target_i),
      .mem             (u_mem.master),
      .if_stall_o      (if_stall_o),
      .if_pc_o         (if_pc_o),
      .if_inst_o       (if_inst_o),
      .if_valid_o      (if_valid_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model: ack is driven on the falling edge so the DUT sees it
   // at the MEM_LAT-th rising edge after the request appeared.
   initial begin
      u_mem.mem_ack_i  = 1'b0;
      u_mem.mem_data_i = NOP_INST;
      mem_cnt          = 0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            u_mem.mem_ack_i = 1'b0;
            mem_cnt         = 0;
         end else if (rdy) begin
            if (u_mem.mem_ack_i) begin
               u_mem.mem_ack_i = 1'b0;
               mem_cnt         = 0;
            end else if (u_mem.mem_req_o) begin
               if (mem_cnt == MEM_LAT - 1) u_mem.mem_ack_i = 1'b1;
               else mem_cnt++;
            end else begin
               mem_cnt = 0;
            end
         end
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Advance until if_valid_o rises; report edges taken and the address of
   // the first newly issued request seen on the way.
   task automatic wait_valid(input string tag, output int cycles, output logic [31:0] new_addr);
      logic prev_req;
      prev_req = u_mem.mem_req_o;
      cycles   = 0;
      new_addr = 32'hdead_beef;
      do begin
         tick();
         cycles++;
         if (u_mem.mem_req_o && !prev_req) new_addr = u_mem.mem_addr_o;
         prev_req = u_mem.mem_req_o;
      end while (!if_valid_o && cycles < 20);
      if (!if_valid_o) check_eq({tag, "_timeout"}, {31'd0, if_valid_o}, 32'd1);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      tick();
      tick();
      rst = 1'b1;
   endtask

   initial begin
      rst = 1'b0; rdy = 1'b1; stall = '0;
      branch_flag_i = 1'b0; branch_target_i = '0;

      // reset state
      tick(); tick();
      check_eq("rst_req",   {31'd0, u_mem.mem_req_o}, 32'd0);
      check_eq("rst_addr",  u_mem.mem_addr_o, 32'h0);
      check_eq("rst_valid", {31'd0, if_valid_o}, 32'd0);
      check_eq("rst_pc",    if_pc_o, 32'h0);
      check_eq("rst_inst",  if_inst_o, 32'h0);
      check_eq("rst_stall", {31'd0, if_stall_o}, 32'd1);
      rst = 1'b1;

      // sequential fetches 0x0, 0x4, 0x8 with one-cycle valid pulses
      for (int i = 0; i < 3; i++) begin
         wait_valid("seq", n, a);
         check_eq("seq_lat",  n, 32'd4);
         check_eq("seq_addr", a, 32'(i * 4));
         check_eq("seq_pc",   if_pc_o, 32'(i * 4));
         check_eq("seq_inst", if_inst_o, 32'h13);
      end
      tick();
      check_eq("seq_pulse", {31'd0, if_valid_o}, 32'd0);

      // IF stall while ack for 0x4 arrives -> HOLD, then release
      do_reset();
      wait_valid("b0", n, a);
      check_eq("b0_pc", if_pc_o, 32'h0);
      tick();
      check_eq("b_req",  {31'd0, u_mem.mem_req_o}, 32'd1);
      check_eq("b_addr", u_mem.mem_addr_o, 32'h4);
      stall = 6'b000011;
      tick(); tick(); tick();
      check_eq("hold_stall", {31'd0, if_stall_o}, 32'd0);
      check_eq("hold_valid", {31'd0, if_valid_o}, 32'd0);
      check_eq("hold_req",   {31'd0, u_mem.mem_req_o}, 32'd0);
      tick();
      check_eq("hold_stay",  {31'd0, if_stall_o}, 32'd0);
      stall = 6'b000000;
      tick();
      check_eq("rel_valid", {31'd0, if_valid_o}, 32'd1);
      check_eq("rel_pc",    if_pc_o, 32'h4);
      check_eq("rel_inst",  if_inst_o, 32'h13);

      // ID stalled: outputs frozen, no bubble, no new request
      stall = 6'b000111;
      for (int i = 0; i < 4; i++) begin
         tick();
         check_eq("frz_valid", {31'd0, if_valid_o}, 32'd1);
         check_eq("frz_pc",    if_pc_o, 32'h4);
      end
      check_eq("frz_req", {31'd0, u_mem.mem_req_o}, 32'd0);
      stall = 6'b000000;
      tick();
      check_eq("unfrz_valid", {31'd0, if_valid_o}, 32'd0);
      check_eq("unfrz_req",   {31'd0, u_mem.mem_req_o}, 32'd1);
      check_eq("unfrz_addr",  u_mem.mem_addr_o, 32'h8);

      // branch to 0x100 one cycle after the request for 0x8
      branch_flag_i = 1'b1; branch_target_i = 32'h100;
      tick();
      branch_flag_i = 1'b0;
      check_eq("disc_req",   {31'd0, u_mem.mem_req_o}, 32'd1);
      check_eq("disc_addr",  u_mem.mem_addr_o, 32'h8);
      check_eq("disc_stall", {31'd0, if_stall_o}, 32'd1);
      wait_valid("br1", n, a);
      check_eq("br1_lat",  n, 32'd6);
      check_eq("br1_addr", a, 32'h100);
      check_eq("br1_pc",   if_pc_o, 32'h100);

      // branch to 0x200 coinciding with the ack for 0x104
      tick();
      check_eq("br2_req_addr", u_mem.mem_addr_o, 32'h104);
      tick(); tick();
      branch_flag_i = 1'b1; branch_target_i = 32'h200;
      tick();
      branch_flag_i = 1'b0;
      check_eq("br2_drop_valid", {31'd0, if_valid_o}, 32'd0);
      check_eq("br2_drop_req",   {31'd0, u_mem.mem_req_o}, 32'd0);
      wait_valid("br2", n, a);
      check_eq("br2_lat",  n, 32'd4);
      check_eq("br2_addr", a, 32'h200);
      check_eq("br2_pc",   if_pc_o, 32'h200);

      // reset in the middle of a fetch at 0x40
      branch_flag_i = 1'b1; branch_target_i = 32'h40;
      tick();
      branch_flag_i = 1'b0;
      check_eq("br3_valid", {31'd0, if_valid_o}, 32'd0);
      tick();
      check_eq("f40_req",  {31'd0, u_mem.mem_req_o}, 32'd1);
      check_eq("f40_addr", u_mem.mem_addr_o, 32'h40);
      rst = 1'b0;
      tick();
      rst = 1'b1;
      check_eq("mrst_req",   {31'd0, u_mem.mem_req_o}, 32'd0);
      check_eq("mrst_addr",  u_mem.mem_addr_o, 32'h0);
      check_eq("mrst_valid", {31'd0, if_valid_o}, 32'd0);
      wait_valid("mrst", n, a);
      check_eq("mrst_lat",  n, 32'd4);
      check_eq("mrst_addr0", a, 32'h0);
      check_eq("mrst_pc",   if_pc_o, 32'h0);

      // rdy low freezes everything for 5 cycles
      rdy = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check_eq("rdy_valid", {31'd0, if_valid_o}, 32'd1);
         check_eq("rdy_pc",    if_pc_o, 32'h0);
         check_eq("rdy_req",   {31'd0, u_mem.mem_req_o}, 32'd0);
      end
      rdy = 1'b1;
      tick();
      check_eq("rdy_go_req",   {31'd0, u_mem.mem_req_o}, 32'd1);
      check_eq("rdy_go_addr",  u_mem.mem_addr_o, 32'h4);
      check_eq("rdy_go_valid", {31'd0, if_valid_o}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
